// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch front end. Issues word-aligned fetch requests to an
// in-order instruction memory, tracks the PC of every request in flight,
// buffers returned instructions for decode and squashes the wrong path when
// execute resolves a taken branch or a jump.
//
// Parameters
//   RESET_PC   first fetch address after reset
//   BUF_DEPTH  instruction-buffer depth, also the cap on outstanding + buffered
//              fetches (legal 1..4)
//
// Ports
//   clk, reset_n          single clock, asynchronous active-low reset
//   pc_src, branch_target taken branch from execute and its destination
//   jalr_flag,
//   jalr_target_offset    resolved jump and its destination (wins over branch)
//   stall                 decode cannot take an instruction this cycle
//   imem_req_valid/ready  request handshake, imem_req_addr is the fetch PC
//   imem_resp_valid/data  in-order read data, >= 1 cycle after acceptance
//   instr_valid           instr_out / pc_out hold the buffer head
//   flush_out             younger pipeline registers must squash this cycle
//   state_dbg             current FSM state, for checkers only
//
// Handshake semantics: every valid/ready pair transfers exactly when both are
// high on a rising edge. A producer that raises valid keeps it and its payload
// stable until the transfer, except that a redirect may replace the request.
// The memory has no ready on its response side: the request cap guarantees
// every response finds buffer space.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pc_src,
  input  logic [31:0] branch_target,
  input  logic        jalr_flag,
  input  logic [31:0] jalr_target_offset,
  input  logic        stall,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        flush_out,
  output logic [1:0]  state_dbg
);

  // Counters must hold 0..4; pointers address a fixed 4-entry storage of
  // which only BUF_DEPTH entries are used.
  localparam int CW = 3;
  localparam int PW = 2;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     req_addr_q, req_addr_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;

  // PCs of live (non-stale) requests, oldest first.
  logic [31:0]     pcq_mem [4];
  logic [PW-1:0]   pcq_rd_q, pcq_wr_q;

  // Instruction buffer seen by decode.
  logic [31:0]     fifo_pc    [4];
  logic [31:0]     fifo_instr [4];
  logic [PW-1:0]   fifo_rd_q, fifo_wr_q;
  logic [CW-1:0]   fifo_cnt_q;

  logic            redirect;
  logic [31:0]     redirect_target;
  logic            handshake;
  logic            resp;
  logic            fifo_push;
  logic            fifo_pop;
  logic            pcq_push;
  logic            pcq_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Redirect and handshake decode
  // ---------------------------------------------------------------------------
  always_comb begin
    redirect        = (state_q != S_BOOT) && (pc_src || jalr_flag);
    redirect_target = jalr_flag ? {jalr_target_offset[31:2], 2'b00}
                                : {branch_target[31:2], 2'b00};
    // Outstanding plus buffered never exceeds the depth, so a response can
    // always be written without back-pressure on the memory.
    imem_req_valid  = (state_q == S_RUN) && ((outst_q + fifo_cnt_q) < DEPTH_C);
    handshake       = imem_req_valid && imem_req_ready;
    resp            = imem_resp_valid;
    instr_valid     = (fifo_cnt_q != '0);

    // Only RUN holds live requests; everything in flight at a redirect is
    // stale, including the request accepted and the response returned in
    // the redirect cycle itself.
    fifo_push       = resp && (state_q == S_RUN) && !redirect;
    fifo_pop        = instr_valid && !stall && !redirect;
    pcq_push        = handshake && !redirect;
    pcq_pop         = fifo_push;

    outst_d         = outst_q + CW'(handshake) - CW'(resp);
  end

  // ---------------------------------------------------------------------------
  // FSM next state, fetch address and stale-response counter
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    drop_d     = drop_q;

    unique case (state_q)
      S_BOOT: begin
        state_d = S_RUN;
      end

      S_RUN: begin
        if (redirect) begin
          req_addr_d = redirect_target;
          drop_d     = outst_d;
          state_d    = (outst_d != '0) ? S_DRAIN : S_RUN;
        end else if (handshake) begin
          req_addr_d = req_addr_q + 32'd4;
        end
      end

      S_DRAIN: begin
        if (resp && (drop_q != '0)) begin
          drop_d = drop_q - CW'(1);
        end
        if (redirect) begin
          req_addr_d = redirect_target;
        end
        state_d = (drop_d == '0) ? S_RUN : S_DRAIN;
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_BOOT;
      req_addr_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Buffer and PC-tracking pointers; both empty on redirect
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else if (redirect) begin
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
    end else begin
      if (fifo_push) fifo_wr_q <= ptr_inc(fifo_wr_q);
      if (fifo_pop)  fifo_rd_q <= ptr_inc(fifo_rd_q);
      fifo_cnt_q <= fifo_cnt_q + CW'(fifo_push) - CW'(fifo_pop);
      if (pcq_push)  pcq_wr_q <= ptr_inc(pcq_wr_q);
      if (pcq_pop)   pcq_rd_q <= ptr_inc(pcq_rd_q);
    end
  end

  // Storage needs no reset: outputs are masked while the buffer is empty.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_pc[fifo_wr_q]    <= pcq_mem[pcq_rd_q];
      fifo_instr[fifo_wr_q] <= imem_resp_data;
    end
    if (pcq_push) begin
      pcq_mem[pcq_wr_q] <= imem_req_addr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    imem_req_addr = req_addr_q;
    instr_out     = instr_valid ? fifo_instr[fifo_rd_q] : '0;
    pc_out        = instr_valid ? fifo_pc[fifo_rd_q]    : '0;
    flush_out     = redirect;
    state_dbg     = state_q;
  end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. The reference model is the architectural instruction
// stream: after reset or a redirect, decode must see target, target+4, ...
// with each word equal to the memory contents at that address. The driver
// loads that stream into exp_q when it issues the reset or redirect; the
// negedge monitor pops and compares every instruction decode accepts. A memory
// model answers requests in order with random latency and tags each request
// with the redirect epoch it was issued in.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] TB_RESET_PC = 32'hFFFF_FFF8;
  localparam int          DEPTH       = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset_n;
  logic        pc_src;
  logic [31:0] branch_target;
  logic        jalr_flag;
  logic [31:0] jalr_target_offset;
  logic        stall;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        flush_out;
  logic [1:0]  state_dbg;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC (TB_RESET_PC),
    .BUF_DEPTH(DEPTH)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .pc_src            (pc_src),
    .branch_target     (branch_target),
    .jalr_flag         (jalr_flag),
    .jalr_target_offset(jalr_target_offset),
    .stall             (stall),
    .imem_req_ready    (imem_req_ready),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .imem_req_valid    (imem_req_valid),
    .imem_req_addr     (imem_req_addr),
    .instr_valid       (instr_valid),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .flush_out         (flush_out),
    .state_dbg         (state_dbg)
  );

  // ---------------------------------------------------------------------------
  // Bench state
  // ---------------------------------------------------------------------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          cycle    = 0;
  int          consumed = 0;
  logic        in_boot  = 1'b0;
  int          lat_min  = 1;
  int          lat_max  = 1;

  logic [31:0] mq_addr [$];
  int          mq_due  [$];
  int          mq_epoch[$];
  int          epoch = 0;

  logic [63:0] exp_q[$];
  logic [31:0] exp_req_addr;

  logic        prev_wait = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_pc   = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] target_of(input logic j, input logic [31:0] jt,
                                            input logic [31:0] bt);
    logic [31:0] t;
    t = j ? jt : bt;
    t[1:0] = 2'b00;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic seed(input logic [31:0] pc);
    logic [31:0] a;
    exp_q.delete();
    for (int i = 0; i < 512; i++) begin
      a = pc + 32'(4 * i);
      exp_q.push_back({a, mem_word(a)});
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance one cycle; inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    in_boot         = 1'b0;
    pc_src          = 1'b0;
    jalr_flag       = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq_addr.size() > 0 && mq_due[0] <= cycle) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
      void'(mq_epoch.pop_front());
    end
  endtask

  task automatic redirect(input logic j, input logic b, input logic [31:0] jt,
                          input logic [31:0] bt);
    jalr_flag          = j;
    pc_src             = b;
    jalr_target_offset = jt;
    branch_target      = bt;
    if (!in_boot && (j || b)) seed(target_of(j, jt, bt));
  endtask

  // Assert reset asynchronously and check the forced values right away.
  task automatic apply_reset(input string tag);
    reset_n = 1'b0;
    pc_src  = 1'b0;
    jalr_flag = 1'b0;
    #1;
    check({tag, "_req_valid"},   32'(imem_req_valid), 32'd0);
    check({tag, "_req_addr"},    imem_req_addr,       TB_RESET_PC);
    check({tag, "_instr_valid"}, 32'(instr_valid),    32'd0);
    check({tag, "_instr_out"},   instr_out,           32'd0);
    check({tag, "_pc_out"},      pc_out,              32'd0);
    check({tag, "_flush_out"},   32'(flush_out),      32'd0);
    mq_addr.delete();
    mq_due.delete();
    mq_epoch.delete();
    imem_resp_valid = 1'b0;
    repeat (2) step();
    mq_addr.delete();
    mq_due.delete();
    mq_epoch.delete();
    imem_resp_valid = 1'b0;
  endtask

  // Release reset just after an edge; the following cycle is BOOT.
  task automatic release_reset();
    step();
    reset_n      = 1'b1;
    in_boot      = 1'b1;
    exp_req_addr = TB_RESET_PC;
    seed(TB_RESET_PC);
  endtask

  // ---------------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    logic        redir;
    logic        hs;
    logic [31:0] tgt;
    logic [63:0] exp;
    int          stale;
    int          lat;
    if (!reset_n) begin
      prev_wait = 1'b0;
      prev_hold = 1'b0;
    end else begin
      redir = !in_boot && (pc_src || jalr_flag);
      tgt   = target_of(jalr_flag, jalr_target_offset, branch_target);
      check("flush_out", 32'(flush_out), 32'(redir));
      if (in_boot) check("boot_no_request", 32'(imem_req_valid), 32'd0);
      if (prev_wait) begin
        check("req_valid_stable", 32'(imem_req_valid), 32'd1);
        check("req_addr_stable",  imem_req_addr,       prev_addr);
      end
      if (prev_hold) begin
        check("stall_hold_valid", 32'(instr_valid), 32'd1);
        check("stall_hold_pc",    pc_out,           prev_pc);
      end

      hs = imem_req_valid && imem_req_ready;
      if (hs) begin
        check("req_addr", imem_req_addr, exp_req_addr);
        stale = 0;
        foreach (mq_epoch[i]) if (mq_epoch[i] != epoch) stale++;
        check("no_request_while_draining", 32'(stale), 32'd0);
        lat = $urandom_range(lat_max, lat_min);
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cycle + lat);
        mq_epoch.push_back(epoch);
        check("inflight_cap", 32'(mq_addr.size() <= DEPTH), 32'd1);
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (redir) begin
        exp_req_addr = tgt;
        epoch++;
      end

      if (instr_valid && !stall && !redir) begin
        if (exp_q.size() == 0) begin
          check("exp_q_underflow", 32'd1, 32'd0);
        end else begin
          exp = exp_q.pop_front();
          check("instr_pc",   pc_out,    exp[63:32]);
          check("instr_word", instr_out, exp[31:0]);
          consumed++;
        end
      end

      prev_wait = imem_req_valid && !imem_req_ready && !redir;
      prev_addr = imem_req_addr;
      prev_hold = instr_valid && stall && !redir;
      prev_pc   = pc_out;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    int  base;
    logic found;
    reset_n            = 1'b0;
    pc_src             = 1'b0;
    branch_target      = '0;
    jalr_flag          = 1'b0;
    jalr_target_offset = '0;
    stall              = 1'b0;
    imem_req_ready     = 1'b1;
    imem_resp_valid    = 1'b0;
    imem_resp_data     = '0;
    exp_req_addr       = TB_RESET_PC;
    seed(TB_RESET_PC);

    repeat (2) @(posedge clk);
    apply_reset("por");

    // Power-up: 1-cycle memory, always ready. A branch during BOOT is ignored.
    lat_min = 1; lat_max = 1;
    release_reset();
    redirect(1'b0, 1'b1, 32'h0, 32'h0000_0040);
    step();
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr",  imem_req_addr,       TB_RESET_PC);
    base = consumed;
    repeat (20) step();
    check("wrap_sequence_progress", 32'(consumed - base >= 3), 32'd1);

    // Decode stalls for 5 cycles, then drains in order.
    stall = 1'b1;
    repeat (5) step();
    stall = 1'b0;
    repeat (15) step();

    // Taken branch with two requests outstanding and nothing buffered.
    lat_min = 3; lat_max = 3;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (mq_addr.size() == 2 && !imem_resp_valid && !instr_valid) begin
        redirect(1'b0, 1'b1, 32'h0, 32'h0000_0100);
        found = 1'b1;
      end
    end
    check("two_outstanding_reached", 32'(found), 32'd1);
    base = consumed;
    repeat (20) step();
    check("branch_resume_progress", 32'(consumed > base), 32'd1);

    // Jump and branch together: the jump wins and its low bits are cleared.
    lat_min = 1; lat_max = 2;
    step();
    redirect(1'b1, 1'b1, 32'h0000_0203, 32'h0000_0040);
    base = consumed;
    repeat (20) step();
    check("jump_resume_progress", 32'(consumed > base), 32'd1);

    // Redirect in a cycle with both a handshake and a response.
    lat_min = 1; lat_max = 1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      step();
      if (imem_req_valid && imem_resp_valid) begin
        redirect(1'b1, 1'b0, 32'h0000_0300, 32'h0);
        found = 1'b1;
      end
    end
    check("hs_resp_redirect_reached", 32'(found), 32'd1);
    repeat (15) step();

    // Random traffic with a reset in the middle.
    for (int i = 0; i < 900; i++) begin
      step();
      if (i == 450) begin
        apply_reset("mid");
        release_reset();
      end else begin
        lat_min        = 1;
        lat_max        = $urandom_range(4, 1);
        stall          = ($urandom_range(3, 0) == 0);
        imem_req_ready = ($urandom_range(3, 0) != 0);
        if ($urandom_range(11, 0) == 0) begin
          if ($urandom_range(7, 0) == 0)
            redirect($urandom_range(1, 0) == 1, 1'b1, 32'hFFFF_FFF4 | $urandom_range(3, 0),
                     32'hFFFF_FFF0 | $urandom_range(3, 0));
          else
            redirect($urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom, $urandom);
        end
      end
    end

    // Quiet drain.
    stall = 1'b0;
    imem_req_ready = 1'b1;
    base = consumed;
    repeat (40) step();
    check("final_drain_progress", 32'(consumed - base >= 10), 32'd1);
    check("total_progress", 32'(consumed >= 200), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
